// File: rtl/arm_mem_sys.sv
// rtl/arm_mem_sys.sv - unified fetch/load-store memory arbitrated onto one shared word RAM
// Optional feature macro ARM_MEM_BYTE_EN: stores honour the DBe byte lanes.
module arm_mem_sys #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        IReq,
    input  logic [31:0] IAdr,
    output logic [31:0] Instr,
    output logic        IValid,
    input  logic        DReq,
    input  logic        DWrite,
    input  logic [31:0] DAdr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  DBe,
    output logic [31:0] ReadData,
    output logic        DValid,
    output logic        Busy,
    output logic        AdrFault
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic          pick_d;
    logic          accept;
    logic          complete;
    logic          port_q;
    logic          last_grant_q;
    logic          wr_q;
    logic          fault_q;
    logic          oor;
    logic [31:0]   adr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   instr_q;
    logic [31:0]   rdata_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          unused_bits;

    assign idx      = adr_q[AW+1:2];
    assign oor      = |(adr_q >> (AW + 2));
    assign Instr    = instr_q;
    assign ReadData = rdata_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        IValid   = 1'b0;
        DValid   = 1'b0;
        Busy     = 1'b0;
        AdrFault = 1'b0;
        // port select: 1 = load/store, 0 = fetch; on a tie the port not granted last wins
        pick_d   = DReq;
        if (IReq && DReq) begin
            pick_d = ~last_grant_q;
        end
        case (state_q)
            IDLE: begin
                if (IReq || DReq) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                Busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    complete = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                Busy     = 1'b1;
                IValid   = ~port_q;
                DValid   = port_q;
                AdrFault = fault_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARM_MEM_BYTE_EN
    logic [3:0] be_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            be_q <= 4'd0;
        end else if (accept) begin
            be_q <= DBe;
        end
    end

    always_ff @(posedge clk) begin
        if (complete && wr_q && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign unused_bits = ^adr_q[1:0];
`else
    always_ff @(posedge clk) begin
        if (complete && wr_q && !oor) begin
            mem[idx] <= wdata_q;
        end
    end

    assign unused_bits = ^{adr_q[1:0], DBe};
`endif

    // RAM array has no reset; only the control and output registers do
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            port_q       <= 1'b0;
            last_grant_q <= 1'b0;
            adr_q        <= 32'd0;
            wr_q         <= 1'b0;
            wdata_q      <= 32'd0;
            cnt_q        <= 4'd0;
            fault_q      <= 1'b0;
            instr_q      <= 32'd0;
            rdata_q      <= 32'd0;
        end else begin
            if (accept) begin
                port_q       <= pick_d;
                last_grant_q <= pick_d;
                adr_q        <= pick_d ? DAdr : IAdr;
                wr_q         <= pick_d & DWrite;
                wdata_q      <= WriteData;
                cnt_q        <= 4'(LATENCY - 1);
            end
            if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (complete) begin
                fault_q <= oor;
                if (port_q) begin
                    rdata_q <= (wr_q || oor) ? 32'd0 : mem[idx];
                end else begin
                    instr_q <= oor ? 32'd0 : mem[idx];
                end
            end
        end
    end
endmodule
